tib_loader: RTL
===============

// Module: tib_loader
// PURPOSE
//  Line-assembly stage directly upstream of the outer interpreter. Takes raw bytes
//  from the UART receiver and builds one input line in the terminal input buffer
//  (TIB) of the 8-bit memory block, with backspace editing. On end-of-line it writes
//  a 0x00 terminator and raises go, the outer interpreter's enable. go stays high
//  until the interpreter reports the buffer is consumed.
// PARAMETERS
//  TIB     'h0   base byte address of the terminal input buffer
//  TIB_SZ  80    max stored chars per line; buffer occupies TIB..TIB+TIB_SZ (terminator)
//  MSZ     8     memory / character data width
//  ASZ     17    memory address width
// PORTS
//  clk     in   1      clock
//  rst     in   1      reset, asynchronous, active-low
//  rx_vld  in   1      UART byte valid
//  rx_dat  in   MSZ    UART byte
//  rx_rdy  out  1      loader accepts byte; transfer when rx_vld && rx_rdy
//  mb_if   mb8_io.master  memory write port: we, ai[ASZ], vi[MSZ]
//  done    in   1      one-cycle strobe from interpreter: terminator reached
//  go      out  1      line ready; drives interpreter en; loader owns memory bus only while go=0
//  len     out  8      current char count (0..TIB_SZ)
//  ovf     out  1      sticky: at least one char dropped on this line
// BEHAVIOUR
//  Reset (rst=0, async): st=ACC, cnt=0, go=0, ovf=0, rx_rdy=1, mb_if.we=0; TIB contents untouched.
//  States: ACC (accumulate) -> TRM (terminate) -> RUN (interpreter active) -> ACC.
//  ACC: rx_rdy=1. On accepted byte b, classified combinationally:
//   - printable 0x20..0x7E, or TAB 0x09 stored as 0x20: if cnt<TIB_SZ, same cycle
//     we=1, ai=TIB+cnt, vi=b; cnt<=cnt+1. If cnt==TIB_SZ: no write, ovf<=1.
//   - BS 0x08 / DEL 0x7F: cnt>0 -> cnt<=cnt-1, no write; cnt==0 -> ignored.
//   - CR 0x0D / LF 0x0A: cnt>0 -> st<=TRM; cnt==0 -> ignored (absorbs CRLF, empty lines).
//   - any other control byte: accepted and dropped.
//  TRM: rx_rdy=0. One cycle with we=1, ai=TIB+cnt, vi=8'h00. Then st<=RUN.
//  RUN: go=1, rx_rdy=0, we=0, ai=0, vi=0. The UART FIFO absorbs input.
//   On done: go<=0, cnt<=0, ovf<=0, st<=ACC. A byte presented in the same cycle is
//   not accepted; it is accepted on the following cycle.
//  done outside RUN is ignored. we is never 1 while go=1.
//  Latency: CR accepted in cycle N; terminator written in N+1; go=1 from N+2.
//   Printable byte write is zero-latency, on the accept cycle.
//  len = cnt, registered. cnt width $clog2(TIB_SZ+1), zero-extended to 8 bits.
//   Elaboration assertions: TIB_SZ<=255; TIB+TIB_SZ < 2**ASZ.
//  Reset mid-line or mid-RUN: immediate return to reset values. A partial line is
//   discarded logically; the next line is written from TIB again.
//  BS after overflow decrements cnt. ovf stays set until done or reset.
// STRUCTURE
//  forthsuper package:
//   - typedef enum logic [1:0] {ACC, TRM, RUN} loader_sts
//   - char constants CH_BS, CH_DEL, CH_TAB, CH_CR, CH_LF, CH_SPC
//   - function ch_class(byte) -> {PRT, EDT, EOL, IGN}
//  Single module, no sub-modules. Next-state and output logic in always_comb;
//   registers in always_ff @(posedge clk, negedge rst).
// TESTING
//  1 "1 2 +"CR -> mem[TIB..TIB+5]=31 20 32 20 2B 00; len=5; go=1 two cycles after CR; held until done.
//  2 "abX",BS,"c",CR -> mem[TIB..]=61 62 63 00; len=3; no write on the BS beat.
//  3 BS at empty, CR, LF, TAB,"x",LF -> go only after final LF; mem[TIB..]=20 78 00; len=2.
//  4 TIB_SZ=4: "123456"CR -> mem[TIB..]=31 32 33 34 00; ovf=1, len=4; after done ovf=0, len=0.
//  5 rx_vld held during RUN -> rx_rdy=0, we=0 throughout; done -> ACC; byte written at TIB next cycle.
//  6 rst low after "ab" (and separately during RUN) -> go=0, len=0, ovf=0 at once; next "z"CR -> mem[TIB]=7A.

Source files
------------

// File: rtl/forthsuper_pkg.sv
// Shared types and character constants for the line loader.
package forthsuper;

  typedef enum logic [1:0] {ACC, TRM, RUN} loader_sts;
  typedef enum logic [1:0] {PRT, EDT, EOL, IGN} ch_cls_t;

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_DEL = 8'h7F;
  localparam logic [7:0] CH_TAB = 8'h09;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_SPC = 8'h20;

  function automatic ch_cls_t ch_class(input logic [7:0] b);
    ch_cls_t c;
    if ((b >= CH_SPC && b <= 8'h7E) || b == CH_TAB) c = PRT;
    else if (b == CH_BS || b == CH_DEL)             c = EDT;
    else if (b == CH_CR || b == CH_LF)              c = EOL;
    else                                            c = IGN;
    return c;
  endfunction

endpackage

// File: rtl/mb8_io.sv
// Write port of the 8-bit memory block.
interface mb8_io #(
  parameter int unsigned ASZ = 17,
  parameter int unsigned MSZ = 8
);
  logic           we;
  logic [ASZ-1:0] ai;
  logic [MSZ-1:0] vi;

  modport master (output we, ai, vi);
  modport slave  (input  we, ai, vi);
endinterface

// File: rtl/tib_loader.sv
// Assembles one edited input line into the TIB, terminates it with 0x00 and holds go
// until the interpreter signals done. Printable writes are same-cycle; rx_rdy=0 outside ACC.
module tib_loader
  import forthsuper::*;
#(
  parameter int unsigned TIB    = 'h0,
  parameter int unsigned TIB_SZ = 80,
  parameter int unsigned MSZ    = 8,
  parameter int unsigned ASZ    = 17
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx_vld,
  input  logic [MSZ-1:0] rx_dat,
  output logic           rx_rdy,
  mb8_io.master          mb_if,
  input  logic           done,
  output logic           go,
  output logic [7:0]     len,
  output logic           ovf
);

  localparam int unsigned CW = $clog2(TIB_SZ + 1);

  if (TIB_SZ > 255) begin : g_bad_sz
    $error("tib_loader: TIB_SZ must not exceed 255");
  end
  if ((longint'(TIB) + longint'(TIB_SZ)) >= (longint'(1) << ASZ)) begin : g_bad_addr
    $error("tib_loader: TIB+TIB_SZ does not fit in ASZ address bits");
  end
  if (MSZ != 8) begin : g_bad_msz
    $error("tib_loader: MSZ must be 8");
  end

  loader_sts      st_q, st_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;

  ch_cls_t        cls;
  logic           accept;
  logic           full;
  logic [ASZ-1:0] wr_addr;
  logic           we_c;
  logic [ASZ-1:0] ai_c;
  logic [MSZ-1:0] vi_c;

  assign cls     = ch_class(rx_dat[7:0]);
  assign accept  = rx_vld && (st_q == ACC);
  assign full    = (cnt_q == CW'(TIB_SZ));
  assign wr_addr = ASZ'(TIB) + ASZ'(cnt_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= ACC;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    case (st_q)
      ACC: begin
        if (accept) begin
          case (cls)
            PRT: begin
              if (full) ovf_d = 1'b1;
              else      cnt_d = cnt_q + CW'(1);
            end
            EDT: if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            // Empty lines never terminate, which also swallows the LF of a CRLF pair.
            EOL: if (cnt_q != '0) st_d = TRM;
            default: ;
          endcase
        end
      end
      TRM: st_d = RUN;
      RUN: begin
        if (done) begin
          st_d  = ACC;
          cnt_d = '0;
          ovf_d = 1'b0;
        end
      end
      default: st_d = ACC;
    endcase
  end

  always_comb begin
    rx_rdy = 1'b0;
    go     = 1'b0;
    we_c   = 1'b0;
    ai_c   = '0;
    vi_c   = '0;
    case (st_q)
      ACC: begin
        rx_rdy = 1'b1;
        if (accept && cls == PRT && !full) begin
          we_c = 1'b1;
          ai_c = wr_addr;
          vi_c = (rx_dat[7:0] == CH_TAB) ? MSZ'(CH_SPC) : rx_dat;
        end
      end
      TRM: begin
        we_c = 1'b1;
        ai_c = wr_addr;
      end
      RUN: go = 1'b1;
      default: ;
    endcase
  end

  assign mb_if.we = we_c;
  assign mb_if.ai = ai_c;
  assign mb_if.vi = vi_c;
  assign len      = 8'(cnt_q);
  assign ovf      = ovf_q;

endmodule
